// File: rtl/rvc_decode_queue.sv
// rvc_decode_queue
//   Front-end stage between instruction fetch and the decoder. Each accepted
//   fetch word is either passed through (32-bit) or expanded from RV32C, is
//   tagged illegal where needed, gets its next fetch PC precomputed, and is
//   stored in a DEPTH-entry FIFO. The decoder therefore sees only 32-bit
//   instructions, and fetch is decoupled from dispatch stalls.
//
// Ports
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   rdy_in                    global enable; 0 freezes all state
//   flush_in                  empties the queue (wins over enq/deq)
//   if_valid/if_ready         fetch-side handshake
//   if_instr/if_pc/if_isjump  fetched word, its PC, predictor taken bit
//   out_valid/out_ready       decoder-side handshake
//   out_instr ... out_nextpc  head entry fields, forced to 0 while empty
//   count                     queue occupancy
module rvc_decode_queue #(
  parameter int          DEPTH = 4,
  parameter int unsigned EN_C  = 1,
  parameter int          CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  input  logic             if_isjump,
  output logic             if_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic             out_is_c,
  output logic             out_illegal,
  output logic             out_isjump,
  output logic [31:0]      out_nextpc,
  output logic [CNT_W-1:0] count
);

  localparam int          PTR_W = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // ---------------------------------------------------------------- expand
  logic [15:0] c;
  logic        is_c;
  logic        exp_ill;
  logic [31:0] exp_instr;
  logic [4:0]  rd, rs2, rd_p, rs1_p;
  logic [11:0] imm6;
  logic [9:0]  addi4_imm;
  logic [6:0]  lw_off;
  logic [7:0]  lwsp_off, swsp_off;
  logic [9:0]  sp16_imm;
  logic [20:0] j_imm;
  logic [12:0] b_imm;
  logic [2:0]  alu_f3;

  assign c = if_instr[15:0];

  always_comb begin
    is_c      = (if_instr[1:0] != 2'b11);
    exp_ill   = 1'b0;
    exp_instr = NOP;
    alu_f3    = 3'b000;
    rd        = c[11:7];
    rs2       = c[6:2];
    rd_p      = {2'b01, c[4:2]};
    rs1_p     = {2'b01, c[9:7]};
    imm6      = {{6{c[12]}}, c[12], c[6:2]};
    addi4_imm = {c[10:7], c[12:11], c[5], c[6], 2'b00};
    lw_off    = {c[5], c[12:10], c[6], 2'b00};
    lwsp_off  = {c[3:2], c[12], c[6:4], 2'b00};
    swsp_off  = {c[8:7], c[12:9], 2'b00};
    sp16_imm  = {c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
    j_imm     = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    b_imm     = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};

    if (!is_c) begin
      exp_instr = if_instr;
    end else if (EN_C == 0) begin
      exp_ill = 1'b1;
    end else begin
      unique case ({c[1:0], c[15:13]})
        5'b00_000: begin // c.addi4spn (also catches 16'h0000)
          if (addi4_imm == '0) exp_ill = 1'b1;
          else exp_instr = {2'b00, addi4_imm, 5'd2, 3'b000, rd_p, 7'b0010011};
        end
        5'b00_010: exp_instr = {5'b0, lw_off, rs1_p, 3'b010, rd_p, 7'b0000011};
        5'b00_110: exp_instr = {5'b0, lw_off[6:5], rd_p, rs1_p, 3'b010, lw_off[4:0], 7'b0100011};
        5'b01_000: exp_instr = {imm6, rd, 3'b000, rd, 7'b0010011};
        5'b01_001,
        5'b01_101: // c.jal links x1, c.j links x0; c[15] tells them apart
          exp_instr = {j_imm[20], j_imm[10:1], j_imm[11], j_imm[19:12],
                       {4'b0000, ~c[15]}, 7'b1101111};
        5'b01_010: exp_instr = {imm6, 5'd0, 3'b000, rd, 7'b0010011};
        5'b01_011: begin
          if (rd == 5'd2) begin
            if (sp16_imm == '0) exp_ill = 1'b1;
            else exp_instr = {{2{c[12]}}, sp16_imm, 5'd2, 3'b000, 5'd2, 7'b0010011};
          end else begin
            if ({c[12], c[6:2]} == '0) exp_ill = 1'b1;
            else exp_instr = {{14{c[12]}}, c[12], c[6:2], rd, 7'b0110111};
          end
        end
        5'b01_100: begin
          unique case (c[11:10])
            2'b00, 2'b01: begin
              // c[10] lands on instr[30], selecting srai over srli
              if (c[12]) exp_ill = 1'b1;
              else exp_instr = {1'b0, c[10], 5'b0, c[6:2], rs1_p, 3'b101, rs1_p, 7'b0010011};
            end
            2'b10: exp_instr = {imm6, rs1_p, 3'b111, rs1_p, 7'b0010011};
            default: begin
              unique case (c[6:5])
                2'b00:   alu_f3 = 3'b000;
                2'b01:   alu_f3 = 3'b100;
                2'b10:   alu_f3 = 3'b110;
                default: alu_f3 = 3'b111;
              endcase
              if (c[12]) exp_ill = 1'b1; // subw/addw: RV64 only
              else exp_instr = {1'b0, (c[6:5] == 2'b00), 5'b0, rd_p, rs1_p, alu_f3,
                                rs1_p, 7'b0110011};
            end
          endcase
        end
        5'b01_110,
        5'b01_111: // c.beqz / c.bnez; c[13] becomes funct3[0]
          exp_instr = {b_imm[12], b_imm[10:5], 5'd0, rs1_p, {2'b00, c[13]},
                       b_imm[4:1], b_imm[11], 7'b1100011};
        5'b10_000: begin
          if (c[12]) exp_ill = 1'b1;
          else exp_instr = {7'b0, c[6:2], rd, 3'b001, rd, 7'b0010011};
        end
        5'b10_010: exp_instr = {4'b0, lwsp_off, 5'd2, 3'b010, rd, 7'b0000011};
        5'b10_100: begin
          if (rs2 == 5'd0) begin
            // c.jr / c.jalr; rs1 = 0 is c.jr-reserved or c.ebreak
            if (rd == 5'd0) exp_ill = 1'b1;
            else exp_instr = {12'b0, rd, 3'b000, {4'b0000, c[12]}, 7'b1100111};
          end else begin
            // c.mv adds to x0, c.add adds to rd
            exp_instr = {7'b0, rs2, (c[12] ? rd : 5'd0), 3'b000, rd, 7'b0110011};
          end
        end
        5'b10_110: exp_instr = {4'b0, swsp_off[7:5], rs2, 5'd2, 3'b010, swsp_off[4:0], 7'b0100011};
        default:   exp_ill = 1'b1;
      endcase
    end

    if (exp_ill) exp_instr = NOP;
  end

  // ---------------------------------------------------------------- next PC
  logic        is_jal, is_branch;
  logic [31:0] jal_off, br_off, exp_nextpc;

  assign is_jal    = (exp_instr[6:0] == 7'b1101111);
  assign is_branch = (exp_instr[6:0] == 7'b1100011);
  assign jal_off   = {{11{exp_instr[31]}}, exp_instr[31], exp_instr[19:12],
                      exp_instr[20], exp_instr[30:21], 1'b0};
  assign br_off    = {{19{exp_instr[31]}}, exp_instr[31], exp_instr[7],
                      exp_instr[30:25], exp_instr[11:8], 1'b0};

  always_comb begin
    exp_nextpc = if_pc + (is_c ? 32'd2 : 32'd4);
    if (is_jal)                      exp_nextpc = if_pc + jal_off;
    else if (is_branch && if_isjump) exp_nextpc = if_pc + br_off;
  end

  // ---------------------------------------------------------------- FIFO
  logic [31:0]      mem_instr  [DEPTH];
  logic [31:0]      mem_pc     [DEPTH];
  logic [31:0]      mem_nextpc [DEPTH];
  logic [2:0]       mem_flags  [DEPTH]; // {is_c, illegal, isjump}
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count_r;
  logic             enq, deq, do_flush;

  assign if_ready  = (count_r != CNT_W'(DEPTH));
  assign out_valid = (count_r != '0);
  assign enq       = if_valid & if_ready & rdy_in;
  assign deq       = out_valid & out_ready & rdy_in;
  assign do_flush  = flush_in & rdy_in;
  assign count     = count_r;

  always_ff @(posedge clk_in) begin
    if (enq && !do_flush) begin
      mem_instr[tail]  <= exp_instr;
      mem_pc[tail]     <= if_pc;
      mem_nextpc[tail] <= exp_nextpc;
      mem_flags[tail]  <= {is_c, exp_ill, is_jal | if_isjump};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else if (do_flush) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign out_instr   = out_valid ? mem_instr[head]    : '0;
  assign out_pc      = out_valid ? mem_pc[head]       : '0;
  assign out_nextpc  = out_valid ? mem_nextpc[head]   : '0;
  assign out_is_c    = out_valid ? mem_flags[head][2] : 1'b0;
  assign out_illegal = out_valid ? mem_flags[head][1] : 1'b0;
  assign out_isjump  = out_valid ? mem_flags[head][0] : 1'b0;

endmodule

// File: tb/tb_rvc_decode_queue.sv
module tb_rvc_decode_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_n_in = 1'b1;
  logic rdy_in = 1'b1, flush_in = 1'b0, if_valid = 1'b0, if_isjump = 1'b0, out_ready = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0;

  logic if_ready, out_valid, out_is_c, out_illegal, out_isjump;
  logic [31:0] out_instr, out_pc, out_nextpc;
  logic [CNT_W-1:0] count;
  logic nc_if_ready, nc_out_valid, nc_out_is_c, nc_out_illegal, nc_out_isjump;
  logic [31:0] nc_out_instr, nc_out_pc, nc_out_nextpc;
  logic [CNT_W-1:0] nc_count;

  rvc_decode_queue #(.DEPTH(DEPTH), .EN_C(1)) u_dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_isjump(if_isjump),
    .if_ready(if_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_is_c(out_is_c),
    .out_illegal(out_illegal), .out_isjump(out_isjump), .out_nextpc(out_nextpc),
    .count(count));

  rvc_decode_queue #(.DEPTH(DEPTH), .EN_C(0)) u_dut_nc (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_isjump(if_isjump),
    .if_ready(nc_if_ready), .out_valid(nc_out_valid), .out_ready(out_ready),
    .out_instr(nc_out_instr), .out_pc(nc_out_pc), .out_is_c(nc_out_is_c),
    .out_illegal(nc_out_illegal), .out_isjump(nc_out_isjump), .out_nextpc(nc_out_nextpc),
    .count(nc_count));

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] nextpc;
    logic        is_c;
    logic        ill;
    logic        isj;
  } ent_t;

  ent_t q1[$];
  ent_t q0[$];
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: field arithmetic + generic encoders
  function automatic int fld(input logic [15:0] c, input int hi, input int lo);
    return int'((32'(c) >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
  endfunction

  function automatic int sx(input int v, input int bits);
    if (((v >> (bits - 1)) & 1) != 0) return v - (1 << bits);
    return v;
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return 32'(((imm & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd, input int op);
    return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3, input int op);
    return 32'((((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm & 31) << 7) | op);
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs1, input int f3);
    return 32'((((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs1 << 15) | (f3 << 12) |
               (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 99);
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return 32'((((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20) |
               (((imm >> 12) & 255) << 12) | (rd << 7) | 111);
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
    return 32'(((imm20 & 'hfffff) << 12) | (rd << 7) | op);
  endfunction

  function automatic ent_t ref_expand(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic isj, input bit en_c);
    ent_t r;
    logic [15:0] c;
    int q, f, rd, rs2, rdp, rs1p, imm6, imm, sub, op;
    int e;
    c = ins[15:0];
    r.pc = pc; r.is_c = (ins[1:0] != 2'b11); r.ill = 1'b0; r.instr = 32'h13; r.isj = isj;
    q = fld(c, 1, 0); f = fld(c, 15, 13);
    rd = fld(c, 11, 7); rs2 = fld(c, 6, 2);
    rdp = 8 + fld(c, 4, 2); rs1p = 8 + fld(c, 9, 7);
    imm6 = sx(fld(c, 12, 12) * 32 + fld(c, 6, 2), 6);
    if (!r.is_c) r.instr = ins;
    else if (!en_c) r.ill = 1'b1;
    else if (q == 0 && f == 0) begin
      imm = fld(c, 12, 11) * 16 + fld(c, 10, 7) * 64 + fld(c, 6, 6) * 4 + fld(c, 5, 5) * 8;
      if (imm == 0) r.ill = 1'b1; else r.instr = enc_i(imm, 2, 0, rdp, 19);
    end else if (q == 0 && (f == 2 || f == 6)) begin
      imm = fld(c, 12, 10) * 8 + fld(c, 6, 6) * 4 + fld(c, 5, 5) * 64;
      r.instr = (f == 2) ? enc_i(imm, rs1p, 2, rdp, 3) : enc_s(imm, rdp, rs1p, 2, 35);
    end else if (q == 1 && f == 0) r.instr = enc_i(imm6, rd, 0, rd, 19);
    else if (q == 1 && (f == 1 || f == 5)) begin
      imm = sx(fld(c, 12, 12) * 2048 + fld(c, 11, 11) * 16 + fld(c, 10, 9) * 256 + fld(c, 8, 8) * 1024 +
               fld(c, 7, 7) * 64 + fld(c, 6, 6) * 128 + fld(c, 5, 3) * 2 + fld(c, 2, 2) * 32, 12);
      r.instr = enc_j(imm, (f == 1) ? 1 : 0);
    end else if (q == 1 && f == 2) r.instr = enc_i(imm6, 0, 0, rd, 19);
    else if (q == 1 && f == 3) begin
      if (rd == 2) begin
        imm = sx(fld(c, 12, 12) * 512 + fld(c, 6, 6) * 16 + fld(c, 5, 5) * 64 + fld(c, 4, 3) * 128 +
                 fld(c, 2, 2) * 32, 10);
        if (imm == 0) r.ill = 1'b1; else r.instr = enc_i(imm, 2, 0, 2, 19);
      end else begin
        if (imm6 == 0) r.ill = 1'b1; else r.instr = enc_u(imm6, rd, 55);
      end
    end else if (q == 1 && f == 4) begin
      sub = fld(c, 11, 10);
      if (sub == 2) r.instr = enc_i(imm6, rs1p, 7, rs1p, 19);
      else if (fld(c, 12, 12) == 1) r.ill = 1'b1;
      else if (sub < 2) r.instr = enc_i(rs2 + ((sub == 1) ? 1024 : 0), rs1p, 5, rs1p, 19);
      else begin
        case (fld(c, 6, 5))
          0: r.instr = enc_r(32, rdp, rs1p, 0, rs1p, 51);
          1: r.instr = enc_r(0, rdp, rs1p, 4, rs1p, 51);
          2: r.instr = enc_r(0, rdp, rs1p, 6, rs1p, 51);
          default: r.instr = enc_r(0, rdp, rs1p, 7, rs1p, 51);
        endcase
      end
    end else if (q == 1 && f >= 6) begin
      imm = sx(fld(c, 12, 12) * 256 + fld(c, 11, 10) * 8 + fld(c, 6, 5) * 64 + fld(c, 4, 3) * 2 +
               fld(c, 2, 2) * 32, 9);
      r.instr = enc_b(imm, rs1p, f - 6);
    end else if (q == 2 && f == 0) begin
      if (fld(c, 12, 12) == 1) r.ill = 1'b1; else r.instr = enc_i(rs2, rd, 1, rd, 19);
    end else if (q == 2 && f == 2) begin
      imm = fld(c, 12, 12) * 32 + fld(c, 6, 4) * 4 + fld(c, 3, 2) * 64;
      r.instr = enc_i(imm, 2, 2, rd, 3);
    end else if (q == 2 && f == 4) begin
      if (rs2 == 0) begin
        if (rd == 0) r.ill = 1'b1; else r.instr = enc_i(0, rd, 0, fld(c, 12, 12), 103);
      end else if (fld(c, 12, 12) == 0) r.instr = enc_r(0, rs2, 0, 0, rd, 51);
      else r.instr = enc_r(0, rs2, rd, 0, rd, 51);
    end else if (q == 2 && f == 6) begin
      imm = fld(c, 12, 9) * 4 + fld(c, 8, 7) * 64;
      r.instr = enc_s(imm, rs2, 2, 2, 35);
    end else r.ill = 1'b1;
    if (r.ill) r.instr = 32'h13;

    e = int'(r.instr);
    op = e & 127;
    r.nextpc = pc + (r.is_c ? 32'd2 : 32'd4);
    if (op == 111) begin
      imm = sx(((e >> 31) & 1) * (1 << 20) + ((e >> 21) & 1023) * 2 + ((e >> 20) & 1) * 2048 +
               ((e >> 12) & 255) * 4096, 21);
      r.nextpc = pc + 32'(imm);
      r.isj = 1'b1;
    end else if (op == 99 && isj) begin
      imm = sx(((e >> 31) & 1) * 4096 + ((e >> 25) & 63) * 32 + ((e >> 8) & 15) * 2 +
               ((e >> 7) & 1) * 2048, 13);
      r.nextpc = pc + 32'(imm);
    end
    return r;
  endfunction

  task automatic check_all();
    ent_t z, h1, h0;
    z = '0;
    h1 = (q1.size() != 0) ? q1[0] : z;
    h0 = (q0.size() != 0) ? q0[0] : z;
    chk("count", 32'(count), 32'(q1.size()));
    chk("if_ready", 32'(if_ready), 32'(q1.size() != DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q1.size() != 0));
    chk("out_instr", out_instr, h1.instr);
    chk("out_pc", out_pc, h1.pc);
    chk("out_nextpc", out_nextpc, h1.nextpc);
    chk("out_is_c", 32'(out_is_c), 32'(h1.is_c));
    chk("out_illegal", 32'(out_illegal), 32'(h1.ill));
    chk("out_isjump", 32'(out_isjump), 32'(h1.isj));
    chk("nc.count", 32'(nc_count), 32'(q0.size()));
    chk("nc.out_instr", nc_out_instr, h0.instr);
    chk("nc.out_nextpc", nc_out_nextpc, h0.nextpc);
    chk("nc.out_illegal", 32'(nc_out_illegal), 32'(h0.ill));
    chk("nc.out_isjump", 32'(nc_out_isjump), 32'(h0.isj));
  endtask

  // One clock: model decides from the inputs held across the edge, then both DUTs are checked.
  task automatic cycle();
    bit enq, deq;
    ent_t e1, e0;
    enq = if_valid && (q1.size() < DEPTH) && rdy_in;
    deq = (q1.size() != 0) && out_ready && rdy_in;
    e1 = ref_expand(if_instr, if_pc, if_isjump, 1'b1);
    e0 = ref_expand(if_instr, if_pc, if_isjump, 1'b0);
    @(posedge clk_in); #1;
    if (rdy_in) begin
      if (flush_in) begin
        q1.delete(); q0.delete();
      end else begin
        if (deq) begin void'(q1.pop_front()); void'(q0.pop_front()); end
        if (enq) begin q1.push_back(e1); q0.push_back(e0); end
      end
    end
    check_all();
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input logic isj);
    if_valid = 1'b1; if_instr = ins; if_pc = pc; if_isjump = isj;
    cycle();
  endtask

  logic [31:0] fill_tab [8] = '{32'h0010_8093, 32'h0000_4581, 32'h0000_852E, 32'hFE00_08E3,
                                32'h0000_C0D9, 32'h0000_1141, 32'h0000_8082, 32'h0000_6105};

  initial begin
    logic [31:0] r;
    int unsigned sel;
    #2 rst_n_in = 1'b0;
    #1;
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.if_ready", 32'(if_ready), 32'd1);
    chk("reset.out_instr", out_instr, 32'd0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    check_all();

    // c.li x10, 5 with junk in the upper half
    out_ready = 1'b0;
    offer(32'hDEAD_4515, 32'h100, 1'b0);
    chk("cli.instr", out_instr, 32'h0050_0513);
    chk("cli.is_c", 32'(out_is_c), 32'd1);
    chk("cli.nextpc", out_nextpc, 32'h102);
    chk("cli.count", 32'(count), 32'd1);

    out_ready = 1'b1;
    offer(32'h0000_852E, 32'h102, 1'b0);
    chk("cmv.instr", out_instr, 32'h00B0_0533);
    offer(32'h0000_A001, 32'h200, 1'b0);
    chk("cj.instr", out_instr, 32'h0000_006F);
    chk("cj.isjump", 32'(out_isjump), 32'd1);
    chk("cj.nextpc", out_nextpc, 32'h200);
    offer(32'h0000_0000, 32'h202, 1'b0);
    chk("zero.illegal", 32'(out_illegal), 32'd1);
    chk("zero.instr", out_instr, 32'h0000_0013);
    offer(32'h0000_4515, 32'h204, 1'b0);
    chk("noc.illegal", 32'(nc_out_illegal), 32'd1);
    chk("noc.instr", nc_out_instr, 32'h0000_0013);
    chk("c.legal", 32'(out_illegal), 32'd0);

    if_valid = 1'b0;
    cycle();
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // fill to DEPTH, then a 5th offer must bounce
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) offer(fill_tab[i], 32'h300 + 32'(i * 4), 1'b1);
    chk("full.count", 32'(count), 32'd4);
    chk("full.if_ready", 32'(if_ready), 32'd0);
    offer(32'h0000_4505, 32'h340, 1'b0);
    chk("full.hold", 32'(count), 32'd4);
    chk("full.head", out_pc, 32'h300);
    out_ready = 1'b1;
    for (int unsigned i = 4; i < 12; i++) offer(fill_tab[i % 8], 32'h400 + 32'(i * 2), 1'(i));
    chk("stream.count", 32'(count), 32'd3);

    flush_in = 1'b1;
    offer(32'h0000_4515, 32'h500, 1'b0);
    flush_in = 1'b0;
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.out_valid", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    offer(32'h0000_4505, 32'h600, 1'b0);
    offer(32'h0000_4509, 32'h602, 1'b0);
    rdy_in = 1'b0; flush_in = 1'b1; out_ready = 1'b1;
    offer(32'h0000_450D, 32'h604, 1'b0);
    chk("freeze.count", 32'(count), 32'd2);
    rdy_in = 1'b1; flush_in = 1'b0;

    for (int unsigned n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 3);
      r = $urandom();
      if (sel == 0) r[1:0] = 2'b11;
      else if (sel == 1) r[6:0] = ($urandom_range(0, 1) != 0) ? 7'h6F : 7'h63;
      if_instr = r;
      if_pc = $urandom() & 32'hFFFF_FFFE;
      if_isjump = 1'($urandom_range(0, 1));
      if_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) != 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      flush_in = ($urandom_range(0, 29) == 0);
      cycle();
    end

    // asynchronous reset in the middle of a cycle
    rdy_in = 1'b1; flush_in = 1'b0; out_ready = 1'b0;
    offer(32'h0000_4515, 32'h700, 1'b0);
    offer(32'h0000_4505, 32'h702, 1'b0);
    #3 rst_n_in = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.nc.out_valid", 32'(nc_out_valid), 32'd0);
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.if_ready", 32'(if_ready), 32'd1);
    q1.delete(); q0.delete();
    @(posedge clk_in); #1;
    rst_n_in = 1'b1; if_valid = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
